wb_boot_arbiter: RTL and testbench
==================================

Name: wb_boot_arbiter

Overview:
- Two-master Wishbone arbiter in front of the shared loader/storage slave (status word 0x3000_0000, size 0x3000_0002, control 0x3000_0003).
- Master 0 is the boot sequencer; master 1 is the CPU data port.
- While boot is incomplete, master 0 has strict priority; after boot, grants alternate round-robin.
- A per-transfer watchdog terminates slave transfers that hang, so no master stalls forever.

Parameters:
- TIMEOUT_CYCLES, 256: cycles a strobed transfer may wait for ACK/ERR/RTY before the arbiter forces ERR. Legal range 2..1024.
- CNT_W, 10: width of the watchdog counter. Must satisfy 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  synchronous, active-high reset
- boot_done_i  in  1  level; 1 selects round-robin policy
- mN_CYC_I, mN_STB_I, mN_WE_I  in  1 each  master N (N=0,1) bus cycle, strobe, write enable
- mN_ADR_I  in  [31:2]  master N word address
- mN_SEL_I  in  4  master N byte selects
- mN_DAT_I  in  32  master N write data
- mN_DAT_O  out  32  read data; s_DAT_I broadcast to both masters
- mN_ACK_O, mN_ERR_O, mN_RTY_O  out  1 each  terminations to master N
- s_CYC_O, s_STB_O, s_WE_O  out  1 each  slave bus cycle, strobe, write enable
- s_ADR_O  out  [31:2]  slave word address
- s_SEL_O  out  4  slave byte selects
- s_DAT_O  out  32  slave write data
- s_DAT_I  in  32  slave read data
- s_ACK_I, s_ERR_I, s_RTY_I  in  1 each  slave terminations
- gnt_o  out  1  currently granted master index
- busy_o  out  1  1 when state is not S_IDLE
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (synchronous):
  - state = S_IDLE; gnt_o = 0; last_gnt = 1; wdog = 0.
  - All s_* outputs = 0; all mN_ACK/ERR/RTY = 0; timeout_o = 0; busy_o = 0.
  - Reset mid-transfer aborts the transfer immediately: s_CYC_O/s_STB_O are low in the cycle after reset is sampled, and no termination is sent to the master.
- States: S_IDLE, S_BUSY, S_TERR.
- S_IDLE:
  - Request is reqN = mN_CYC_I & mN_STB_I.
  - Winner selection:
    - Only one request: that master wins.
    - Both request and boot_done_i = 0: master 0 wins.
    - Both request and boot_done_i = 1: the master != last_gnt wins.
  - On a winner: next state S_BUSY, gnt_o and last_gnt <= winner.
  - s_CYC_O is 0 in S_IDLE, so grant latency is 1 cycle from request.
- S_BUSY:
  - s_CYC/STB/WE/ADR/SEL/DAT_O combinationally equal the granted master's inputs.
  - Slave ACK/ERR/RTY are routed to the granted master only; the other master's terminations stay 0.
  - Grant is held while the granted master's CYC_I = 1 (supports locked/burst cycles). The other master's requests are ignored.
  - Granted CYC_I = 0: next state S_IDLE. This gives exactly one idle bus cycle between grants.
- Watchdog (S_BUSY only):
  - wdog clears on any s_ACK_I/s_ERR_I/s_RTY_I, when granted STB_I = 0, and on entry to S_BUSY.
  - Otherwise wdog increments by 1.
  - When wdog == TIMEOUT_CYCLES-1 with no termination in that cycle: next state S_TERR.
  - A termination arriving in the same cycle as the limit wins; the watchdog does not fire.
- S_TERR (1 cycle):
  - s_CYC_O = s_STB_O = 0.
  - Granted mN_ERR_O = 1; timeout_o = 1; wdog = 0.
  - Next state S_BUSY if granted CYC_I = 1 (master may retry), else S_IDLE.
  - Late slave terminations arriving in S_TERR are dropped.
- Invariants:
  - At most one mN_ACK/ERR/RTY high at any time.
  - s_STB_O implies s_CYC_O.
  - gnt_o changes only on S_IDLE -> S_BUSY.
- A change of boot_done_i while in S_BUSY does not affect the current grant.

Decomposition:
- Shared package wb_pkg:
  - state typedef for S_IDLE/S_BUSY/S_TERR.
  - Loader address constants: ADDR_STATUS 30'h3000_0000, ADDR_SIZE 30'h3000_0002, ADDR_CONTROL 30'h3000_0003.
  - Wishbone master/slave signal-group structs.
- One sub-module, wb_wdog_counter: clear, enable, limit inputs; expired output.
- Mux and arbitration logic stay in the top level.

Test Plan:
- Boot priority: boot_done_i=0, m0 and m1 both request in the same cycle -> gnt_o=0. s_ADR_O=30'h3000_0000 from the next cycle. m1 is granted only after m0 drops CYC plus 1 idle cycle.
- Round-robin: boot_done_i=1, both masters request continuously with 1-beat transfers, ACK after 2 cycles -> grants alternate 0,1,0,1 across 4 transfers.
- Locked cycle: m1 holds CYC for 3 ACKed beats (STB low between beats) while m0 requests -> m0 ACK/ERR/RTY stay 0 throughout; m0 granted 1 cycle after m1 CYC falls.
- Timeout: TIMEOUT_CYCLES=4, slave never ACKs m0 read -> S_TERR in cycle 4 after grant. m0_ERR_O=1 and timeout_o=1 for exactly 1 cycle; s_CYC_O=0 in that cycle.
- Race at limit: s_ACK_I arrives in the cycle where wdog=TIMEOUT_CYCLES-1 -> m0_ACK_O=1, no ERR, timeout_o stays 0.
- Reset mid-transfer: RTI_I asserted during m1 write to 30'h3000_0002 -> next cycle all outputs at reset values, gnt_o=0, state S_IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the boot-time Wishbone arbiter.
// Loader register map and bus signal groups.
package wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_TERR
    } state_t;

    localparam logic [29:0] ADDR_STATUS  = 30'h3000_0000;
    localparam logic [29:0] ADDR_SIZE    = 30'h3000_0002;
    localparam logic [29:0] ADDR_CONTROL = 30'h3000_0003;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } wb_rsp_t;

endpackage

// File: rtl/wb_wdog_counter.sv
// Per-transfer watchdog: counts stalled strobe cycles.
// expired is high while the count sits at the limit.
module wb_wdog_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/wb_boot_arbiter.sv
// Two-master Wishbone arbiter: boot sequencer priority until boot_done,
// then round-robin, with a watchdog that forces ERR on hung transfers.
module wb_boot_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 10
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        boot_done_i,
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [31:2] m0_ADR_I,
    input  logic [3:0]  m0_SEL_I,
    input  logic [31:0] m0_DAT_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,
    output logic        m0_RTY_O,
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [31:2] m1_ADR_I,
    input  logic [3:0]  m1_SEL_I,
    input  logic [31:0] m1_DAT_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,
    output logic        m1_RTY_O,
    output logic        s_CYC_O,
    output logic        s_STB_O,
    output logic        s_WE_O,
    output logic [31:2] s_ADR_O,
    output logic [3:0]  s_SEL_O,
    output logic [31:0] s_DAT_O,
    input  logic [31:0] s_DAT_I,
    input  logic        s_ACK_I,
    input  logic        s_ERR_I,
    input  logic        s_RTY_I,
    output logic        gnt_o,
    output logic        busy_o,
    output logic        timeout_o
);

    state_t  state, state_nx;
    logic    gnt_nx, last_gnt, last_nx, winner;
    wb_req_t m0, m1, bus;
    wb_rsp_t rsp, rsp_p;
    logic    req0, req1, term;
    logic    wd_clear, wd_en, wd_expired, wd_fire;

    assign m0  = '{cyc: m0_CYC_I, stb: m0_STB_I, we: m0_WE_I,
                   adr: m0_ADR_I, sel: m0_SEL_I, dat: m0_DAT_I};
    assign m1  = '{cyc: m1_CYC_I, stb: m1_STB_I, we: m1_WE_I,
                   adr: m1_ADR_I, sel: m1_SEL_I, dat: m1_DAT_I};
    assign bus = gnt_o ? m1 : m0;
    assign rsp = '{ack: s_ACK_I, err: s_ERR_I, rty: s_RTY_I};

    // One termination at a time even if the slave misbehaves.
    assign rsp_p = '{ack: rsp.ack,
                     err: rsp.err & ~rsp.ack,
                     rty: rsp.rty & ~rsp.ack & ~rsp.err};

    assign req0 = m0_CYC_I & m0_STB_I;
    assign req1 = m1_CYC_I & m1_STB_I;
    assign term = s_ACK_I | s_ERR_I | s_RTY_I;

    assign wd_en    = (state == S_BUSY);
    assign wd_clear = ~wd_en | term | ~bus.stb;
    assign wd_fire  = wd_en & bus.cyc & bus.stb & ~term & wd_expired;

    wb_wdog_counter #(.CNT_W(CNT_W)) u_wdog (
        .clk     (CLK_I),
        .rst     (RST_I),
        .clear   (wd_clear),
        .enable  (wd_en),
        .limit   (CNT_W'(TIMEOUT_CYCLES - 1)),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= S_IDLE;
            gnt_o    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nx;
            gnt_o    <= gnt_nx;
            last_gnt <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_o;
        last_nx  = last_gnt;
        winner   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req0 && req1) begin
                    winner = boot_done_i ? ~last_gnt : 1'b0;
                end else begin
                    winner = req1;
                end
                if (req0 || req1) begin
                    state_nx = S_BUSY;
                    gnt_nx   = winner;
                    last_nx  = winner;
                end
            end
            S_BUSY: begin
                if (!bus.cyc) begin
                    state_nx = S_IDLE;
                end else if (wd_fire) begin
                    state_nx = S_TERR;
                end
            end
            S_TERR: begin
                state_nx = bus.cyc ? S_BUSY : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        s_CYC_O  = 1'b0;
        s_STB_O  = 1'b0;
        s_WE_O   = 1'b0;
        s_ADR_O  = '0;
        s_SEL_O  = '0;
        s_DAT_O  = '0;
        m0_ACK_O = 1'b0;
        m0_ERR_O = 1'b0;
        m0_RTY_O = 1'b0;
        m1_ACK_O = 1'b0;
        m1_ERR_O = 1'b0;
        m1_RTY_O = 1'b0;
        if (state == S_BUSY) begin
            s_CYC_O = bus.cyc;
            s_STB_O = bus.cyc & bus.stb;
            s_WE_O  = bus.we;
            s_ADR_O = bus.adr;
            s_SEL_O = bus.sel;
            s_DAT_O = bus.dat;
            if (gnt_o) begin
                {m1_ACK_O, m1_ERR_O, m1_RTY_O} = rsp_p;
            end else begin
                {m0_ACK_O, m0_ERR_O, m0_RTY_O} = rsp_p;
            end
        end else if (state == S_TERR) begin
            m0_ERR_O = ~gnt_o;
            m1_ERR_O = gnt_o;
        end
    end

    assign m0_DAT_O  = s_DAT_I;
    assign m1_DAT_O  = s_DAT_I;
    assign busy_o    = (state != S_IDLE);
    assign timeout_o = (state == S_TERR);

endmodule

// File: tb/tb_wb_boot_arbiter.sv
// Directed bench for wb_boot_arbiter with a 4-cycle watchdog.
// Covers boot priority, round-robin, locked cycles, timeout and reset.
module tb_wb_boot_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:2] m0_adr;
    logic [3:0]  m0_sel;
    logic [31:0] m0_dat, m0_rdat;
    logic        m0_ack, m0_err, m0_rty;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:2] m1_adr;
    logic [3:0]  m1_sel;
    logic [31:0] m1_dat, m1_rdat;
    logic        m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [31:2] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_wdat, s_rdat;
    logic        s_ack, s_err, s_rty;
    logic        gnt, busy, tmo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_boot_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(10)) dut (
        .CLK_I(clk), .RST_I(rst), .boot_done_i(boot_done),
        .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we),
        .m0_ADR_I(m0_adr), .m0_SEL_I(m0_sel), .m0_DAT_I(m0_dat),
        .m0_DAT_O(m0_rdat), .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err),
        .m0_RTY_O(m0_rty),
        .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we),
        .m1_ADR_I(m1_adr), .m1_SEL_I(m1_sel), .m1_DAT_I(m1_dat),
        .m1_DAT_O(m1_rdat), .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err),
        .m1_RTY_O(m1_rty),
        .s_CYC_O(s_cyc), .s_STB_O(s_stb), .s_WE_O(s_we),
        .s_ADR_O(s_adr), .s_SEL_O(s_sel), .s_DAT_O(s_wdat),
        .s_DAT_I(s_rdat), .s_ACK_I(s_ack), .s_ERR_I(s_err),
        .s_RTY_I(s_rty),
        .gnt_o(gnt), .busy_o(busy), .timeout_o(tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; boot_done = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0;
        m0_sel = 4'hF; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0;
        m1_sel = 4'hF; m1_dat = '0;
        s_rdat = 32'hDEAD_BEEF; s_ack = 0; s_err = 0; s_rty = 0;
        nxt; nxt;
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);

        // boot priority
        m0_cyc = 1; m0_stb = 1; m0_adr = ADDR_STATUS;
        m1_cyc = 1; m1_stb = 1; m1_adr = ADDR_SIZE;
        #1;
        chk("boot_idle_scyc", 32'(s_cyc), 32'd0);
        nxt;
        chk("boot_gnt0", 32'(gnt), 32'd0);
        chk("boot_adr", 32'(s_adr), 32'(ADDR_STATUS));
        chk("boot_scyc", 32'(s_cyc), 32'd1);
        s_ack = 1;
        #1;
        chk("boot_m0ack", 32'(m0_ack), 32'd1);
        chk("boot_m1ack", 32'(m1_ack), 32'd0);
        chk("rdat_bcast", m1_rdat, 32'hDEAD_BEEF);
        nxt;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        nxt;
        chk("boot_gap", 32'(busy), 32'd0);
        nxt;
        chk("boot_gnt1", 32'(gnt), 32'd1);
        chk("boot_adr1", 32'(s_adr), 32'(ADDR_SIZE));
        s_ack = 1;
        #1;
        chk("boot_m1ack1", 32'(m1_ack), 32'd1);
        chk("boot_m0ack1", 32'(m0_ack), 32'd0);
        nxt;
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        nxt;

        // round-robin
        boot_done = 1'b1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int k = 0; k < 4; k++) begin
            nxt;
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(k % 2));
            nxt;
            s_ack = 1;
            #1;
            chk($sformatf("rr_ack%0d", k),
                32'({m1_ack, m0_ack}), (k % 2) ? 32'd2 : 32'd1);
            nxt;
            s_ack = 0;
            if (k % 2) begin m1_cyc = 0; m1_stb = 0; end
            else begin m0_cyc = 0; m0_stb = 0; end
            nxt;
            chk($sformatf("rr_gap%0d", k), 32'(busy), 32'd0);
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        nxt;

        // locked m1 cycle with m0 waiting
        m1_cyc = 1; m1_stb = 1;
        nxt;
        chk("lock_gnt1", 32'(gnt), 32'd1);
        m0_cyc = 1; m0_stb = 1; m0_adr = ADDR_STATUS;
        for (int b = 0; b < 3; b++) begin
            s_ack = 1;
            #1;
            chk($sformatf("lock_m1ack%0d", b), 32'(m1_ack), 32'd1);
            chk($sformatf("lock_m0t%0d", b),
                32'({m0_ack, m0_err, m0_rty}), 32'd0);
            nxt;
            s_ack = 0; m1_stb = 0;
            if (b == 2) m1_cyc = 0;
            #1;
            chk($sformatf("lock_hold%0d", b), 32'(gnt), 32'd1);
            chk($sformatf("lock_m0q%0d", b),
                32'({m0_ack, m0_err, m0_rty}), 32'd0);
            nxt;
            if (b < 2) m1_stb = 1;
        end
        chk("lock_gap", 32'(busy), 32'd0);
        nxt;
        chk("lock_gnt0", 32'(gnt), 32'd0);

        // timeout: m0 read never answered
        chk("to_t0", 32'(tmo), 32'd0);
        nxt; nxt; nxt;
        chk("to_t3", 32'(tmo), 32'd0);
        chk("to_scyc3", 32'(s_cyc), 32'd1);
        nxt;
        s_ack = 1;
        #1;
        chk("to_tmo", 32'(tmo), 32'd1);
        chk("to_m0err", 32'(m0_err), 32'd1);
        chk("to_m1err", 32'(m1_err), 32'd0);
        chk("to_scyc", 32'(s_cyc), 32'd0);
        chk("to_late_ack", 32'(m0_ack), 32'd0);
        nxt;
        s_ack = 0;
        #1;
        chk("to_retry_busy", 32'(busy), 32'd1);
        chk("to_once", 32'({tmo, m0_err}), 32'd0);

        // ACK at the watchdog limit wins
        nxt; nxt; nxt;
        s_ack = 1;
        #1;
        chk("race_ack", 32'(m0_ack), 32'd1);
        chk("race_err", 32'(m0_err), 32'd0);
        nxt;
        s_ack = 0;
        #1;
        chk("race_tmo", 32'(tmo), 32'd0);
        chk("race_busy", 32'(busy), 32'd1);
        m0_cyc = 0; m0_stb = 0;
        nxt;

        // reset during an m1 write
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = ADDR_SIZE;
        m1_sel = 4'hC; m1_dat = 32'hA5A5_0001;
        nxt;
        chk("wr_gnt", 32'(gnt), 32'd1);
        chk("wr_we", 32'(s_we), 32'd1);
        chk("wr_dat", s_wdat, 32'hA5A5_0001);
        chk("wr_sel", 32'(s_sel), 32'hC);
        rst = 1'b1;
        nxt;
        s_ack = 1;
        #1;
        chk("mrst_gnt", 32'(gnt), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_s", 32'({s_cyc, s_stb, s_we}), 32'd0);
        chk("mrst_adr", 32'(s_adr), 32'd0);
        chk("mrst_m1t", 32'({m1_ack, m1_err, m1_rty}), 32'd0);
        rst = 1'b0; s_ack = 0;
        m0_cyc = 1; m0_stb = 1;
        nxt;
        chk("mrst_rr_gnt", 32'(gnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
